// File: rtl/mmio_input_hub_if.sv
// CPU-side and channel-side signals of the multi-channel input hub.
// The master modport is the bus driver. The slave modport is the hub.
interface mmio_input_hub_if #(
    parameter int N_CH = 4,
    parameter int DW   = 16,
    parameter int AW   = 12
);
    logic [N_CH-1:0][DW-1:0] ch_data;
    logic [N_CH-1:0]         ch_strobe;
    logic [AW-1:0]           address;
    logic                    memwt;
    logic                    rd_en;
    logic [DW-1:0]           wr_data;
    logic [DW-1:0]           rd_data;
    logic                    hit;
    logic                    ovf_any;

    modport master (
        output ch_data, ch_strobe, address, memwt, rd_en, wr_data,
        input  rd_data, hit, ovf_any
    );
    modport slave (
        input  ch_data, ch_strobe, address, memwt, rd_en, wr_data,
        output rd_data, hit, ovf_any
    );
endinterface

// File: rtl/mmio_input_hub.sv
// Memory-mapped input hub. Each channel captures its word on a strobe rising edge.
// The word goes into a small FIFO. The CPU polls STAT and pops the FIFO through DATA.
module mmio_input_ch #(
    parameter int DW          = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int PW         = $clog2(DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] data,
    input  logic          strobe,
    input  logic          pop,
    input  logic          flush,
    input  logic          clr_ovf,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count,
    output logic          not_empty,
    output logic          full,
    output logic          ovf
);
    logic [SYNC_STAGES-1:0]  sync_pipe;
    logic                    strobe_q;
    logic [DEPTH-1:0][DW-1:0] mem;
    logic [PW-1:0]           wp, rp;
    logic                    push, do_push, do_pop;

    assign push      = sync_pipe[SYNC_STAGES-1] & ~strobe_q;
    assign not_empty = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop & not_empty;
    // A pop at the same edge frees the slot that a push on a full FIFO needs.
    assign do_push   = push & (~full | do_pop);
    assign head      = mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_pipe <= '0;
            strobe_q  <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], strobe};
            strobe_q  <= sync_pipe[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem   <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (clr_ovf)
                ovf <= 1'b0;
            // Flush wins over a same-cycle push. That push is dropped silently.
            if (flush) begin
                wp    <= '0;
                rp    <= '0;
                count <= '0;
            end else begin
                if (do_push) begin
                    mem[wp] <= data;
                    wp      <= wp + PW'(1);
                end
                if (do_pop)
                    rp <= rp + PW'(1);
                if (push && full && !do_pop)
                    ovf <= 1'b1;
                count <= count + CW'(do_push) - CW'(do_pop);
            end
        end
    end
endmodule

module mmio_input_hub #(
    parameter int            N_CH        = 4,
    parameter int            DW          = 16,
    parameter int            AW          = 12,
    parameter int            FIFO_DEPTH  = 4,
    parameter logic [AW-1:0] BASE_ADDR   = 12'h900,
    parameter int            SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              reset,
    mmio_input_hub_if.slave  bus
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int WIN = 2 * N_CH + 1;

    logic [AW-1:0]           off;
    logic                    in_win, gstat_sel, gclr, ovf_or;
    logic [N_CH-1:0]         pop, stat_wr, ne, full, ovf;
    logic [N_CH-1:0][DW-1:0] head, stat;
    logic [N_CH-1:0][CW-1:0] cnt;
    logic                    unused_wr;

    assign off       = bus.address - BASE_ADDR;
    assign in_win    = (bus.address >= BASE_ADDR) &&
                       ({1'b0, bus.address} < ({1'b0, BASE_ADDR} + (AW+1)'(WIN)));
    assign gstat_sel = in_win && (off == AW'(2 * N_CH));
    assign gclr      = gstat_sel & bus.memwt & bus.wr_data[DW-1];
    assign unused_wr = ^bus.wr_data;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign pop[i]     = in_win & bus.rd_en & ~bus.memwt & (off == AW'(2 * i));
        assign stat_wr[i] = in_win & bus.memwt & (off == AW'(2 * i + 1));
        assign stat[i]    = DW'({cnt[i], 1'b0, ovf[i], full[i], ne[i]});

        mmio_input_ch #(
            .DW(DW), .DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .data      (bus.ch_data[i]),
            .strobe    (bus.ch_strobe[i]),
            .pop       (pop[i]),
            .flush     (stat_wr[i] & bus.wr_data[DW-1]),
            .clr_ovf   ((stat_wr[i] & bus.wr_data[2]) | gclr),
            .head      (head[i]),
            .count     (cnt[i]),
            .not_empty (ne[i]),
            .full      (full[i]),
            .ovf       (ovf[i])
        );
    end

    assign ovf_or      = |ovf;
    assign bus.ovf_any = ovf_or;
    assign bus.hit     = in_win & ~reset;

    always_comb begin
        bus.rd_data = '0;
        if (in_win && !reset) begin
            if (gstat_sel) begin
                bus.rd_data[N_CH-1:0] = ne;
                bus.rd_data[DW-1]     = ovf_or;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (off == AW'(2 * i))
                    bus.rd_data = ne[i] ? head[i] : '0;
                else if (off == AW'(2 * i + 1))
                    bus.rd_data = stat[i];
            end
        end
    end
endmodule

// File: tb/tb_mmio_input_hub.sv
// Randomized, self-checking bench for mmio_input_hub.
// It compares the DUT against a queue-based reference model.
module tb_mmio_input_hub;
    localparam int          N     = 4;
    localparam int          DEPTH = 4;
    localparam logic [11:0] BASE  = 12'h900;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mmio_input_hub_if #(.N_CH(N), .DW(16), .AW(12)) bus ();

    mmio_input_hub #(
        .N_CH(N), .DW(16), .AW(12), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int passed = 0;

    // Reference model: one queue of words and one sticky overflow bit per channel.
    logic [15:0] mq [N][$];
    bit          movf [N];

    function automatic logic [11:0] a_data(int ch); return BASE + 12'(2 * ch);     endfunction
    function automatic logic [11:0] a_stat(int ch); return BASE + 12'(2 * ch + 1); endfunction
    function automatic logic [11:0] a_gstat();      return BASE + 12'(2 * N);      endfunction

    function automatic logic [15:0] exp_stat(int ch);
        int sz = mq[ch].size();
        return 16'(sz << 4) | (movf[ch] ? 16'h4 : 16'h0) |
               ((sz == DEPTH) ? 16'h2 : 16'h0) | ((sz != 0) ? 16'h1 : 16'h0);
    endfunction

    function automatic logic [15:0] exp_gstat();
        logic [15:0] v = '0;
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() != 0) v[i] = 1'b1;
            if (movf[i]) v[15] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [15:0] m_head(int ch);
        return (mq[ch].size() != 0) ? mq[ch][0] : 16'h0000;
    endfunction

    function automatic void m_push(int ch, logic [15:0] d);
        if (mq[ch].size() == DEPTH) movf[ch] = 1'b1;
        else mq[ch].push_back(d);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            movf[i] = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [15:0] v);
        bus.address = a;
        bus.rd_en   = 1'b0;
        bus.memwt   = 1'b0;
        #1;
        v = bus.rd_data;
    endtask

    task automatic pop(input int ch, output logic [15:0] v);
        bus.address = a_data(ch);
        bus.memwt   = 1'b0;
        bus.rd_en   = 1'b1;
        #1;
        v = bus.rd_data;
        tick();
        bus.rd_en = 1'b0;
        if (mq[ch].size() != 0) void'(mq[ch].pop_front());
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        bus.address = a;
        bus.wr_data = d;
        bus.rd_en   = 1'b0;
        bus.memwt   = 1'b1;
        tick();
        bus.memwt = 1'b0;
        if (a == a_gstat() && d[15]) begin
            for (int i = 0; i < N; i++) movf[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (a == a_stat(i)) begin
                if (d[2])  movf[i] = 1'b0;
                if (d[15]) mq[i].delete();
            end
        end
    endtask

    // Raise the strobes in mask, wait until the push lands, then release and let the sync drain.
    task automatic press(input logic [N-1:0] mask, input logic [N-1:0][15:0] d);
        bus.ch_data   = d;
        bus.ch_strobe = mask;
        repeat (3) tick();
        for (int i = 0; i < N; i++) if (mask[i]) m_push(i, d[i]);
        bus.ch_strobe = '0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [15:0] v;
        bus.address = BASE;
        #2;
        total++; if (bus.rd_data !== 16'h0) $display("FAIL reset_rd_data got=%h exp=0000", bus.rd_data); else passed++;
        total++; if (bus.hit !== 1'b0)      $display("FAIL reset_hit got=%b exp=0", bus.hit); else passed++;
        total++; if (bus.ovf_any !== 1'b0)  $display("FAIL reset_ovf_any got=%b exp=0", bus.ovf_any); else passed++;
        repeat (2) tick();
        reset = 1'b0;
        m_reset();
        tick();
        rd(a_stat(0), v);
        total++; if (v !== 16'h0000) $display("FAIL reset_stat0 got=%h exp=0000", v); else passed++;
    endtask

    task automatic test_capture();
        logic [15:0] v;
        tick();
        bus.ch_data[0] = 16'h1E47;
        bus.ch_strobe  = 4'b0001;
        repeat (2) tick();
        rd(a_stat(0), v);
        total++; if (v !== 16'h0000) $display("FAIL capture_early got=%h exp=0000", v); else passed++;
        tick();
        m_push(0, 16'h1E47);
        rd(a_stat(0), v);
        total++; if (v !== 16'h0011) $display("FAIL capture_3clk got=%h exp=0011", v); else passed++;
        repeat (17) tick();
        bus.ch_strobe = '0;
        rd(a_stat(0), v);
        total++; if (v !== exp_stat(0)) $display("FAIL capture_held got=%h exp=%h", v, exp_stat(0)); else passed++;
        repeat (4) tick();
        pop(0, v);
        total++; if (v !== 16'h1E47) $display("FAIL capture_pop got=%h exp=1e47", v); else passed++;
        rd(a_stat(0), v);
        total++; if (v !== 16'h0000) $display("FAIL capture_stat_after got=%h exp=0000", v); else passed++;
    endtask

    task automatic test_order_wrap();
        logic [15:0]         v;
        logic [N-1:0][15:0]  d = '0;
        int                  nxt = 1;
        tick();
        for (int k = 1; k <= 4; k++) begin d[1] = 16'hA000 + 16'(k); press(4'b0010, d); end
        for (int k = 0; k < 2; k++) begin
            pop(1, v);
            total++; if (v !== 16'hA000 + 16'(nxt)) $display("FAIL order_pop got=%h exp=%h", v, 16'hA000 + 16'(nxt)); else passed++;
            nxt++;
        end
        for (int k = 5; k <= 6; k++) begin d[1] = 16'hA000 + 16'(k); press(4'b0010, d); end
        for (int k = 0; k < 4; k++) begin
            pop(1, v);
            total++; if (v !== 16'hA000 + 16'(nxt)) $display("FAIL wrap_pop got=%h exp=%h", v, 16'hA000 + 16'(nxt)); else passed++;
            nxt++;
        end
        rd(a_stat(1), v);
        total++; if (v !== 16'h0000) $display("FAIL wrap_stat got=%h exp=0000", v); else passed++;
    endtask

    task automatic test_overflow();
        logic [15:0]        v, e;
        logic [N-1:0][15:0] d = '0;
        tick();
        for (int k = 0; k < 5; k++) begin d[2] = 16'($urandom); press(4'b0100, d); end
        rd(a_stat(2), v);
        total++; if (v !== 16'h0047) $display("FAIL ovf_stat got=%h exp=0047", v); else passed++;
        total++; if (bus.ovf_any !== 1'b1) $display("FAIL ovf_any_set got=%b exp=1", bus.ovf_any); else passed++;
        tick();
        for (int k = 0; k < 4; k++) begin
            e = m_head(2);
            pop(2, v);
            total++; if (v !== e) $display("FAIL ovf_pop got=%h exp=%h", v, e); else passed++;
        end
        wr(a_stat(2), 16'h0004);
        rd(a_stat(2), v);
        total++; if (v !== 16'h0000) $display("FAIL ovf_clear got=%h exp=0000", v); else passed++;
        total++; if (bus.ovf_any !== 1'b0) $display("FAIL ovf_any_clr got=%b exp=0", bus.ovf_any); else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [15:0]        v, e, nw;
        logic [N-1:0][15:0] d = '0;
        tick();
        for (int k = 0; k < 4; k++) begin d[3] = 16'($urandom); press(4'b1000, d); end
        nw = 16'($urandom);
        d[3] = nw;
        bus.ch_data   = d;
        bus.ch_strobe = 4'b1000;
        repeat (2) tick();
        // The push lands on the next edge, together with this pop.
        e = m_head(3);
        pop(3, v);
        m_push(3, nw);
        bus.ch_strobe = '0;
        total++; if (v !== e) $display("FAIL fullpp_pop got=%h exp=%h", v, e); else passed++;
        repeat (4) tick();
        rd(a_stat(3), v);
        total++; if (v !== 16'h0043) $display("FAIL fullpp_stat got=%h exp=0043", v); else passed++;
        tick();
        for (int k = 0; k < 4; k++) begin
            e = m_head(3);
            pop(3, v);
            total++; if (v !== e) $display("FAIL fullpp_drain got=%h exp=%h", v, e); else passed++;
        end
        total++; if (v !== nw) $display("FAIL fullpp_last got=%h exp=%h", v, nw); else passed++;
    endtask

    task automatic test_gstat_flush();
        logic [15:0]        v;
        logic [N-1:0][15:0] d;
        tick();
        d = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        press(4'b0101, d);
        rd(a_gstat(), v);
        total++; if (v !== 16'h0005) $display("FAIL gstat_two got=%h exp=0005", v); else passed++;
        tick();
        wr(a_stat(0), 16'h8000);
        rd(a_gstat(), v);
        total++; if (v !== 16'h0004) $display("FAIL gstat_flush got=%h exp=0004", v); else passed++;
        tick();
        pop(0, v);
        total++; if (v !== 16'h0000) $display("FAIL empty_pop got=%h exp=0000", v); else passed++;
        rd(a_gstat(), v);
        total++; if (v !== 16'h0004) $display("FAIL empty_pop_state got=%h exp=0004", v); else passed++;
        // A flush that lands on the push edge discards the push.
        tick();
        bus.ch_strobe = 4'b0100;
        repeat (2) tick();
        wr(a_stat(2), 16'h8000);
        bus.ch_strobe = '0;
        repeat (4) tick();
        rd(a_stat(2), v);
        total++; if (v !== 16'h0000) $display("FAIL flush_vs_push got=%h exp=0000", v); else passed++;
        rd(BASE + 12'd8, v);
        total++; if (bus.hit !== 1'b1) $display("FAIL hit_last got=%b exp=1", bus.hit); else passed++;
        rd(BASE + 12'd9, v);
        total++; if (bus.hit !== 1'b0 || v !== 16'h0) $display("FAIL hit_above got=%b/%h exp=0/0000", bus.hit, v); else passed++;
        rd(BASE - 12'd1, v);
        total++; if (bus.hit !== 1'b0 || v !== 16'h0) $display("FAIL hit_below got=%b/%h exp=0/0000", bus.hit, v); else passed++;
    endtask

    task automatic test_random();
        logic [15:0]        v, e, wd;
        logic [N-1:0][15:0] d;
        int                 ch;
        logic [11:0]        a;
        tick();
        for (int it = 0; it < 60; it++) begin
            ch = $urandom_range(0, N - 1);
            case ($urandom_range(0, 3))
                0, 1: begin
                    d = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
                    press(4'($urandom_range(1, 15)), d);
                end
                2: begin
                    e = m_head(ch);
                    pop(ch, v);
                    total++; if (v !== e) $display("FAIL rand_pop ch=%0d got=%h exp=%h", ch, v, e); else passed++;
                end
                default: begin
                    wd = 16'($urandom) & 16'h7FFF;
                    if ($urandom_range(0, 3) == 0) wd[15] = 1'b1;
                    a = ($urandom_range(0, 4) == 0) ? a_gstat() : a_stat(ch);
                    wr(a, wd);
                end
            endcase
            rd(a_stat(ch), v);
            total++; if (v !== exp_stat(ch)) $display("FAIL rand_stat ch=%0d got=%h exp=%h", ch, v, exp_stat(ch)); else passed++;
            rd(a_gstat(), v);
            total++; if (v !== exp_gstat()) $display("FAIL rand_gstat got=%h exp=%h", v, exp_gstat()); else passed++;
            total++; if (bus.ovf_any !== exp_gstat()[15]) $display("FAIL rand_ovf_any got=%b exp=%b", bus.ovf_any, exp_gstat()[15]); else passed++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0]        v;
        logic [N-1:0][15:0] d = '0;
        d[0] = 16'($urandom);
        press(4'b0001, d);
        bus.address   = a_stat(0);
        bus.ch_strobe = 4'b0010;
        tick();
        #($urandom_range(0, 2));
        reset = 1'b1;
        #1;
        total++; if (bus.rd_data !== 16'h0) $display("FAIL rstmid_rd_data got=%h exp=0000", bus.rd_data); else passed++;
        total++; if (bus.hit !== 1'b0)      $display("FAIL rstmid_hit got=%b exp=0", bus.hit); else passed++;
        total++; if (bus.ovf_any !== 1'b0)  $display("FAIL rstmid_ovf_any got=%b exp=0", bus.ovf_any); else passed++;
        bus.ch_strobe = '0;
        repeat (2) tick();
        reset = 1'b0;
        m_reset();
        repeat (4) tick();
        rd(a_stat(0), v);
        total++; if (v !== 16'h0000) $display("FAIL rstmid_stat0 got=%h exp=0000", v); else passed++;
        rd(a_gstat(), v);
        total++; if (v !== 16'h0000) $display("FAIL rstmid_gstat got=%h exp=0000", v); else passed++;
    endtask

    initial begin
        bus.ch_data   = '0;
        bus.ch_strobe = '0;
        bus.address   = '0;
        bus.memwt     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.wr_data   = '0;
        test_reset();
        test_capture();
        test_order_wrap();
        test_overflow();
        test_full_push_pop();
        test_gstat_flush();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
